// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared types for the cache-line arbiter
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

  function automatic arb_state_t busy_state(input arb_req_t id);
    return (id == REQ_I) ? BUSY_I : BUSY_D;
  endfunction

endpackage

// File: rtl/arb_grant_select.sv
// rtl/arb_grant_select.sv - combinational I/D grant picker
import lc3b_types::*;

module arb_grant_select #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic     i_pending_i,
  input  logic     d_pending_i,
  input  arb_req_t last_grant_i,
  output logic     grant_valid_o,
  output arb_req_t grant_id_o
);

  always_comb begin
    grant_valid_o = i_pending_i | d_pending_i;
    grant_id_o    = REQ_D;
    if (i_pending_i && d_pending_i) begin
      // On a tie, round-robin hands the grant to whoever did not win last time
      if (RR_ENABLE) begin
        grant_id_o = (last_grant_i == REQ_I) ? REQ_D : REQ_I;
      end else begin
        grant_id_o = REQ_D;
      end
    end else if (i_pending_i) begin
      grant_id_o = REQ_I;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// rtl/cacheline_arbiter.sv - shares one cache-line memory port between I and D caches
import lc3b_types::*;

module cacheline_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128,
  parameter bit          RR_ENABLE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  arb_state_t            state_q, state_d;
  arb_req_t              last_grant_q, last_grant_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic     i_pending, d_pending;
  logic     grant_valid;
  arb_req_t grant_id;

  assign i_pending = i_read | i_write;
  assign d_pending = d_read | d_write;

  arb_grant_select #(
    .RR_ENABLE(RR_ENABLE)
  ) u_grant_select (
    .i_pending_i  (i_pending),
    .d_pending_i  (d_pending),
    .last_grant_i (last_grant_q),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= REQ_D;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_id;
          state_d      = busy_state(grant_id);
          // Write wins when a requester raises both strobes
          if (grant_id == REQ_I) begin
            mem_write_d   = i_write;
            mem_read_d    = i_read & ~i_write;
            mem_address_d = i_address;
            mem_wdata_d   = i_wdata;
          end else begin
            mem_write_d   = d_write;
            mem_read_d    = d_read & ~d_write;
            mem_address_d = d_address;
            mem_wdata_d   = d_wdata;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign i_resp      = (state_q == BUSY_I) & mem_resp;
  assign d_resp      = (state_q == BUSY_D) & mem_resp;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb/tb_cacheline_arbiter.sv - directed self-checking bench for cacheline_arbiter
module tb_cacheline_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_read = 1'b0, i_write = 1'b0;
  logic [15:0]  i_address = '0;
  logic [127:0] i_wdata = '0;
  logic         d_read = 1'b0, d_write = 1'b0;
  logic [15:0]  d_address = '0;
  logic [127:0] d_wdata = '0;
  logic         mem_resp = 1'b0;
  logic [127:0] mem_rdata = '0;

  logic         i_resp, d_resp, mem_read, mem_write;
  logic [127:0] i_rdata, d_rdata, mem_wdata;
  logic [15:0]  mem_address;

  logic         f_i_resp, f_d_resp, f_mem_read, f_mem_write;
  logic [127:0] f_i_rdata, f_d_rdata, f_mem_wdata;
  logic [15:0]  f_mem_address;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cacheline_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  cacheline_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_ENABLE(1'b0)) dut_fixed (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(f_i_resp), .i_rdata(f_i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(f_d_resp), .d_rdata(f_d_rdata),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_address(f_mem_address),
    .mem_wdata(f_mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] RDATA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] A5    = {16{8'hA5}};

  logic [1:0] rr_seen [4];
  logic [1:0] fx_seen [4];
  int         d_pulses;

  initial begin
    // Reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      i_read = 1'($urandom); i_write = 1'($urandom); d_read = 1'($urandom); d_write = 1'($urandom);
      i_address = 16'($urandom); d_address = 16'($urandom);
      i_wdata = {4{$urandom}}; d_wdata = {4{$urandom}};
      mem_resp = 1'($urandom);
      tick();
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_resp", {i_resp, d_resp}, 0);
    end
    i_read = 0; i_write = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
    #2 rst = 0;
    tick();
    check("idle_mem_read", mem_read, 0);

    // I read
    i_read = 1; i_address = 16'h0040;
    tick();
    check("iread_mem_read", mem_read, 1);
    check("iread_mem_write", mem_write, 0);
    check("iread_mem_address", mem_address, 16'h0040);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("iread_wait_resp", {i_resp, d_resp}, 0);
      check("iread_hold", mem_read, 1);
    end
    mem_resp = 1; mem_rdata = RDATA;
    #1;
    check("iread_i_resp", i_resp, 1);
    check("iread_i_rdata", i_rdata, RDATA);
    check("iread_d_resp", d_resp, 0);
    tick();
    mem_resp = 0; i_read = 0;
    check("iread_mem_read_clr", mem_read, 0);
    #1;
    check("iread_i_resp_clr", i_resp, 0);
    tick();

    // D write with address/data changed after the grant
    d_write = 1; d_address = 16'h1230; d_wdata = A5;
    tick();
    check("dwr_mem_write", mem_write, 1);
    check("dwr_mem_read", mem_read, 0);
    check("dwr_mem_address", mem_address, 16'h1230);
    check("dwr_mem_wdata", mem_wdata, A5);
    d_address = 16'hFFFF; d_wdata = '0;
    d_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (d_resp) d_pulses++;
    end
    check("dwr_addr_held", mem_address, 16'h1230);
    check("dwr_wdata_held", mem_wdata, A5);
    mem_resp = 1;
    #1;
    if (d_resp) d_pulses++;
    check("dwr_i_resp", i_resp, 0);
    tick();
    mem_resp = 0; d_write = 0;
    check("dwr_mem_write_clr", mem_write, 0);
    // Stray mem_resp while in DONE must not produce a response
    mem_resp = 1;
    #1;
    if (d_resp) d_pulses++;
    check("done_resp_ignored", {i_resp, d_resp}, 0);
    tick();
    mem_resp = 0;
    check("dwr_d_resp_count", d_pulses, 1);

    // Tie right after reset: I first, D request at R+3
    rst = 1; #1; rst = 0;
    tick();
    i_read = 1; i_address = 16'h0100; d_read = 1; d_address = 16'h0200;
    tick();
    check("tie_first_addr", mem_address, 16'h0100);
    check("tie_fixed_first_addr", f_mem_address, 16'h0200);
    tick();
    mem_resp = 1;
    #1;
    check("tie_i_resp", {i_resp, d_resp}, 2'b10);
    tick();
    mem_resp = 0; i_read = 0;
    check("tie_r1_idle", mem_read, 0);
    tick();
    check("tie_r2_idle", mem_read, 0);
    tick();
    check("tie_r3_read", mem_read, 1);
    check("tie_r3_addr", mem_address, 16'h0200);
    tick();
    mem_resp = 1;
    #1;
    check("tie_d_resp", {i_resp, d_resp}, 2'b01);
    tick();
    mem_resp = 0; d_read = 0;
    tick();

    // Sustained contention on both parameterisations
    rst = 1; #1; rst = 0;
    tick();
    i_read = 1; d_read = 1; i_address = 16'h0A00; d_address = 16'h0D00;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      mem_resp = 1;
      #1;
      rr_seen[k] = {i_resp, d_resp};
      fx_seen[k] = {f_i_resp, f_d_resp};
      tick();
      mem_resp = 0;
      tick();
    end
    check("rr_grant0", rr_seen[0], 2'b10);
    check("rr_grant1", rr_seen[1], 2'b01);
    check("rr_grant2", rr_seen[2], 2'b10);
    check("rr_grant3", rr_seen[3], 2'b01);
    check("fixed_grant0", fx_seen[0], 2'b01);
    check("fixed_grant1", fx_seen[1], 2'b01);
    check("fixed_grant2", fx_seen[2], 2'b01);
    check("fixed_grant3", fx_seen[3], 2'b01);
    i_read = 0; d_read = 0;
    tick();
    tick();

    // Reset during BUSY_D
    d_write = 1; d_address = 16'h0300; d_wdata = A5;
    tick();
    check("rmid_busy_write", mem_write, 1);
    i_read = 1; i_address = 16'h0440;
    #2 rst = 1;
    #1;
    check("rmid_write_drop", mem_write, 0);
    check("rmid_addr_zero", mem_address, 0);
    check("rmid_wdata_zero", mem_wdata, 0);
    mem_resp = 1;
    #1;
    check("rmid_no_d_resp", d_resp, 0);
    mem_resp = 0;
    #1 rst = 0;
    tick();
    check("rmid_i_first_read", mem_read, 1);
    check("rmid_i_first_write", mem_write, 0);
    check("rmid_i_first_addr", mem_address, 16'h0440);
    i_read = 0; d_write = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
